// File: rtl/rv32i_types.sv
// Shared types for the CPU memory-side arbiter.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    DONE_A,
    DONE_B
  } arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } arb_port_t;

endpackage

// File: rtl/rr_grant.sv
// Two-requester round-robin grant; the winner is remembered only when the
// grant is actually taken, so idle cycles do not disturb fairness.
module rr_grant
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      req_a,
  input  logic      req_b,
  input  logic      take,
  output logic      grant_any,
  output arb_port_t grant
);

  arb_port_t last_grant;

  assign grant_any = req_a | req_b;

  always_comb begin
    grant = PORT_A;
    if (req_a && req_b)
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    else if (req_b)
      grant = PORT_B;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= PORT_A;
    else if (take && grant_any)
      last_grant <= grant;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the instruction (A) and data (B) ports onto one downstream memory
// port, returning a one-cycle response pulse to the requester.
//
// state  | meaning
// IDLE   | sample requests, grant one port, latch its command
// BUSY_A | fetch read in flight downstream
// BUSY_B | data read/write in flight downstream
// DONE_A | resp_a pulse; requests ignored this cycle
// DONE_B | resp_b pulse; requests ignored this cycle
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,
  input  logic                read_b,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_wmask,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  arb_state_t state;
  arb_port_t  grant;
  logic       grant_any;
  logic       req_b;
  logic       in_idle;

  assign req_b   = read_b | write;
  assign in_idle = (state == IDLE);

  rr_grant u_rr_grant (
    .clk       (clk),
    .rst       (rst),
    .req_a     (read_a),
    .req_b     (req_b),
    .take      (in_idle),
    .grant_any (grant_any),
    .grant     (grant)
  );

  // The pmem_* registers double as the latched command, so later request
  // changes cannot leak downstream while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_a       <= 1'b0;
      resp_b       <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
    end else begin
      resp_a <= 1'b0;
      resp_b <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            if (grant == PORT_B) begin
              pmem_address <= address_b;
              pmem_wdata   <= wdata;
              pmem_wmask   <= wmask;
              pmem_write   <= write;
              pmem_read    <= ~write;
              state        <= BUSY_B;
            end else begin
              pmem_address <= address_a;
              pmem_wdata   <= '0;
              pmem_wmask   <= '0;
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
              state        <= BUSY_A;
            end
          end
        end
        BUSY_A: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            rdata_a   <= pmem_rdata;
            resp_a    <= 1'b1;
            state     <= DONE_A;
          end
        end
        BUSY_B: begin
          if (pmem_resp) begin
            if (pmem_read)
              rdata_b <= pmem_rdata;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            resp_b     <= 1'b1;
            state      <= DONE_B;
          end
        end
        DONE_A, DONE_B: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

endmodule
